// File: rtl/logo_scroll_ctrl_if.sv
// Interface between the VGA sync / control side and the logo scroll sequencer.
// The sequencer uses the slave modport; the driving side uses master.
interface logo_scroll_ctrl_if;
    logic        vsync;
    logic        start;
    logic        stop;
    logic [10:0] delt;
    logic        logo_en;
    logic        moving;
    logic        dir;
    logic        frame_tick;

    modport master (
        output vsync, start, stop,
        input  delt, logo_en, moving, dir, frame_tick
    );

    modport slave (
        input  vsync, start, stop,
        output delt, logo_en, moving, dir, frame_tick
    );
endinterface

// File: rtl/logo_scroll_ctrl.sv
// Per-frame sequencer for the logo horizontal offset: ping-pongs delt between
// 0 and DELT_MAX on frame ticks, dwelling at each end.
module logo_scroll_ctrl #(
    parameter int unsigned DELT_MAX    = 100,
    parameter int unsigned STEP        = 2,
    parameter int unsigned FRAME_DIV   = 1,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned VS_ACT_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    logo_scroll_ctrl_if.slave  bus
);
    localparam int unsigned DW = 11;
    localparam int unsigned SW = DW + 1;
    localparam int unsigned CW = 8;
    localparam int unsigned HW = 16;
    localparam logic        VS_IDLE = (VS_ACT_LOW != 0);

    typedef enum logic [1:0] {IDLE, RIGHT, LEFT, HOLD} state_t;

    state_t        state;
    logic          vsync_q;
    logic          tick_q;
    logic          dir_q;
    logic          moving_q;
    logic          en_q;
    logic [DW-1:0] delt_q;
    logic [CW-1:0] div_cnt;
    logic [HW-1:0] hold_cnt;

    logic          edge_c;
    logic          update_c;
    logic [SW-1:0] sum_c;
    logic [DW-1:0] right_c;
    logic [DW-1:0] left_c;

    // Frame start is the transition out of the inactive vsync level.
    assign edge_c   = VS_IDLE ? (vsync_q & ~bus.vsync) : (~vsync_q & bus.vsync);
    assign update_c = tick_q && (div_cnt == CW'(FRAME_DIV - 1));

    // Sum is one bit wider than delt so the clamp sees overflow past DELT_MAX.
    assign sum_c   = {1'b0, delt_q} + SW'(STEP);
    assign right_c = (sum_c >= SW'(DELT_MAX)) ? DW'(DELT_MAX) : sum_c[DW-1:0];
    assign left_c  = (delt_q < DW'(STEP)) ? '0 : (delt_q - DW'(STEP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vsync_q  <= VS_IDLE;
            tick_q   <= 1'b0;
            dir_q    <= 1'b0;
            moving_q <= 1'b0;
            en_q     <= 1'b0;
            delt_q   <= '0;
            div_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            vsync_q <= bus.vsync;
            tick_q  <= edge_c;
            en_q    <= 1'b1;
            if (bus.stop) begin
                state    <= IDLE;
                moving_q <= 1'b0;
                div_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state    <= dir_q ? LEFT : RIGHT;
                            moving_q <= 1'b1;
                        end
                    end
                    RIGHT: begin
                        if (update_c) begin
                            div_cnt <= '0;
                            delt_q  <= right_c;
                            if (right_c == DW'(DELT_MAX)) begin
                                state    <= HOLD;
                                dir_q    <= 1'b1;
                                hold_cnt <= '0;
                            end
                        end else if (tick_q) begin
                            div_cnt <= div_cnt + CW'(1);
                        end
                    end
                    LEFT: begin
                        if (update_c) begin
                            div_cnt <= '0;
                            delt_q  <= left_c;
                            if (left_c == '0) begin
                                state    <= HOLD;
                                dir_q    <= 1'b0;
                                hold_cnt <= '0;
                            end
                        end else if (tick_q) begin
                            div_cnt <= div_cnt + CW'(1);
                        end
                    end
                    HOLD: begin
                        // Exit is checked every clock so a zero dwell needs no tick.
                        if (hold_cnt == HW'(HOLD_FRAMES)) begin
                            state <= dir_q ? LEFT : RIGHT;
                        end else if (tick_q) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.delt       = delt_q;
    assign bus.logo_en    = en_q;
    assign bus.moving     = moving_q;
    assign bus.dir        = dir_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// Bench for logo_scroll_ctrl: two differently-parameterised instances share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_logo_scroll_ctrl;
    localparam int NI = 2;
    localparam int P_MAX  [NI] = '{100, 9};
    localparam int P_STEP [NI] = '{2, 2};
    localparam int P_DIV  [NI] = '{1, 3};
    localparam int P_HOLD [NI] = '{30, 0};
    localparam int P_LOW  [NI] = '{1, 0};

    logic clk = 1'b0;
    logic rst;
    logic vsync;
    logic start;
    logic stop;

    int n_cmp = 0;
    int n_bad = 0;

    logo_scroll_ctrl_if bus_a ();
    logo_scroll_ctrl_if bus_b ();

    assign bus_a.vsync = vsync;
    assign bus_a.start = start;
    assign bus_a.stop  = stop;
    assign bus_b.vsync = vsync;
    assign bus_b.start = start;
    assign bus_b.stop  = stop;

    logo_scroll_ctrl #(
        .DELT_MAX(100), .STEP(2), .FRAME_DIV(1), .HOLD_FRAMES(30), .VS_ACT_LOW(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    logo_scroll_ctrl #(
        .DELT_MAX(9), .STEP(2), .FRAME_DIV(3), .HOLD_FRAMES(0), .VS_ACT_LOW(0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: position, heading, and whether travelling or dwelling.
    int m_pos   [NI];
    int m_dir   [NI];
    int m_run   [NI];
    int m_dwell [NI];
    int m_frames[NI];
    int m_wait  [NI];
    int m_tick  [NI];
    int m_vs    [NI];
    int m_en    [NI];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_pos[k] = 0; m_dir[k] = 0; m_run[k] = 0; m_dwell[k] = 0;
                m_frames[k] = 0; m_wait[k] = 0; m_tick[k] = 0; m_en[k] = 0;
                m_vs[k] = P_LOW[k];
            end else begin
                int was_tick;
                int tgt;
                was_tick  = m_tick[k];
                m_tick[k] = (P_LOW[k] != 0) ? int'(m_vs[k] == 1 && vsync == 1'b0)
                                            : int'(m_vs[k] == 0 && vsync == 1'b1);
                m_vs[k]   = int'(vsync);
                m_en[k]   = 1;
                if (stop) begin
                    m_run[k] = 0; m_dwell[k] = 0; m_frames[k] = 0;
                end else if (m_run[k] == 0 && m_dwell[k] == 0) begin
                    if (start) m_run[k] = 1;
                end else if (m_dwell[k] != 0) begin
                    if (m_wait[k] >= P_HOLD[k]) begin
                        m_dwell[k] = 0; m_run[k] = 1;
                    end else if (was_tick != 0) begin
                        m_wait[k]++;
                    end
                end else if (was_tick != 0) begin
                    m_frames[k]++;
                    if (m_frames[k] == P_DIV[k]) begin
                        m_frames[k] = 0;
                        tgt = (m_dir[k] != 0) ? m_pos[k] - P_STEP[k] : m_pos[k] + P_STEP[k];
                        if (tgt < 0) tgt = 0;
                        if (tgt > P_MAX[k]) tgt = P_MAX[k];
                        m_pos[k] = tgt;
                        if ((m_dir[k] == 0 && tgt == P_MAX[k]) || (m_dir[k] != 0 && tgt == 0)) begin
                            m_dir[k] = 1 - m_dir[k];
                            m_run[k] = 0; m_dwell[k] = 1; m_wait[k] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp("a.delt",       int'(bus_a.delt),       m_pos[0]);
        cmp("a.dir",        int'(bus_a.dir),        m_dir[0]);
        cmp("a.moving",     int'(bus_a.moving),     int'(m_run[0] != 0 || m_dwell[0] != 0));
        cmp("a.logo_en",    int'(bus_a.logo_en),    m_en[0]);
        cmp("a.frame_tick", int'(bus_a.frame_tick), m_tick[0]);
        cmp("b.delt",       int'(bus_b.delt),       m_pos[1]);
        cmp("b.dir",        int'(bus_b.dir),        m_dir[1]);
        cmp("b.moving",     int'(bus_b.moving),     int'(m_run[1] != 0 || m_dwell[1] != 0));
        cmp("b.logo_en",    int'(bus_b.logo_en),    m_en[1]);
        cmp("b.frame_tick", int'(bus_b.frame_tick), m_tick[1]);
    end

    // All stimulus tasks start and end 1 time unit after a rising clock edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        cycles($urandom_range(3, 6));
        vsync = 1'b1;
        cycles($urandom_range(3, 8));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycles(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cycles(1); stop = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        cmp("rst.a.delt",   int'(bus_a.delt),   0);
        cmp("rst.a.moving", int'(bus_a.moving), 0);
        cmp("rst.a.dir",    int'(bus_a.dir),    0);
        cmp("rst.b.delt",   int'(bus_b.delt),   0);
        cycles(2);
        rst = 1'b0;
        #1 cmp("rst.a.en_low", int'(bus_a.logo_en), 0);
        cycles(1);
        cmp("rst.a.en_high", int'(bus_a.logo_en), 1);
        cycles(2);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; start = 1'b0; stop = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(4);

        // First frame by hand: tick one cycle after the edge, delt one cycle later.
        pulse_start();
        vsync = 1'b0;
        cycles(1);
        cmp("lat.tick",     int'(bus_a.frame_tick), 1);
        cmp("lat.delt_old", int'(bus_a.delt),       0);
        cycles(1);
        cmp("lat.tick_off", int'(bus_a.frame_tick), 0);
        cmp("lat.delt_new", int'(bus_a.delt),       2);
        cycles(3);
        vsync = 1'b1;
        cycles(4);
        frames(4);
        cmp("scroll.a5", int'(bus_a.delt), 10);
        cmp("scroll.b5", int'(bus_b.delt), 2);
        frames(15);
        cmp("scroll.a20", int'(bus_a.delt), 40);
        cmp("scroll.b20", int'(bus_b.delt), 7);
        cmp("scroll.b20dir", int'(bus_b.dir), 1);

        do_reset();

        // Full sweep of the default instance into the dwell and back down.
        pulse_start();
        frames(9);
        cmp("div.b9", int'(bus_b.delt), 6);
        cmp("div.a9", int'(bus_a.delt), 18);
        frames(41);
        cmp("end.a50", int'(bus_a.delt), 100);
        cmp("end.a50dir", int'(bus_a.dir), 1);
        frames(30);
        cmp("dwell.a80", int'(bus_a.delt), 100);
        frames(1);
        cmp("dwell.a81", int'(bus_a.delt), 98);
        frames(39);
        cmp("ret.a120", int'(bus_a.delt), 20);

        pulse_stop();
        frames(5);
        cmp("stop.delt",   int'(bus_a.delt),   20);
        cmp("stop.moving", int'(bus_a.moving), 0);
        cmp("stop.dir",    int'(bus_a.dir),    1);
        pulse_start();
        frames(1);
        cmp("resume.delt", int'(bus_a.delt), 18);
        pulse_stop();
        cycles(2);
        start = 1'b1; stop = 1'b1;
        cycles(1);
        start = 1'b0; stop = 1'b0;
        cycles(2);
        cmp("both.moving", int'(bus_a.moving), 0);
        frames(2);
        cmp("both.delt", int'(bus_a.delt), 18);

        // Randomised phase: irregular vsync, sporadic start/stop pulses.
        begin
            int run_left;
            run_left = $urandom_range(1, 8);
            for (int c = 0; c < 4000; c++) begin
                start = ($urandom_range(0, 19) == 0);
                stop  = ($urandom_range(0, 149) == 0);
                run_left--;
                if (run_left == 0) begin
                    vsync    = ~vsync;
                    run_left = $urandom_range(1, 8);
                end
                cycles(1);
            end
            start = 1'b0; stop = 1'b0;
        end

        do_reset();
        cycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
